bsg_aes_input_gather: RTL and testbench

Upstream front-end for `bsg_aes_encrypt`. It accepts a narrow stream of tagged words (key words and plaintext words) over a valid/ready link and holds the current 256-bit key. It assembles each 128-bit plaintext block and presents the 384-bit frame `{plaintext, key}` to the encrypt core's `data_i`/`v_i`/`ready_o` port. Loading the key once covers every following block until a new key is loaded.

---
 rtl/bsg_aes_pkg.sv | 18 +
 rtl/bsg_aes_shift_in.sv | 46 ++++
 rtl/bsg_aes_input_gather.sv | 187 ++++++++++++++++++
 tb/tb_bsg_aes_input_gather.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_aes_pkg.sv
// Shared widths and the gather FSM state type for the AES front-end.
//   bsg_aes_block_width_gp : plaintext block width
//   bsg_aes_key_width_gp   : key width
//   bsg_aes_frame_width_gp : {block, key} frame width handed to the encrypt core
package bsg_aes_pkg;

  localparam int bsg_aes_block_width_gp = 128;
  localparam int bsg_aes_key_width_gp   = 256;
  localparam int bsg_aes_frame_width_gp = bsg_aes_block_width_gp + bsg_aes_key_width_gp;

  typedef enum logic [1:0] {
    S_NOKEY = 2'd0,
    S_KEY   = 2'd1,
    S_BLK   = 2'd2,
    S_FULL  = 2'd3
  } bsg_aes_gather_state_e;

endpackage

// File: rtl/bsg_aes_shift_in.sv
// Enable-gated shift-in register with clear. Each enabled cycle shifts the
// register left by one word and inserts data_i at the LSB end, so the first
// word loaded ends up in the MSBs once width_p/word_width_p words are in.
//   clk_i     : clock
//   reset_n_i : synchronous active-low reset, clears contents
//   clear_i   : synchronous clear (lower priority than reset, higher than en_i)
//   en_i      : shift in data_i this cycle
//   data_i    : word to insert
//   data_o    : full register contents
module bsg_aes_shift_in
  import bsg_aes_pkg::*;
#(
  parameter int width_p      = bsg_aes_block_width_gp,
  parameter int word_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic [word_width_p-1:0] data_i,
  output logic [width_p-1:0]      data_o
);

  logic [width_p-1:0] data_r;
  logic [width_p-1:0] shifted;

  // A single-word register has nothing to keep when shifting.
  if (width_p == word_width_p) begin : g_single
    assign shifted = data_i;
  end else begin : g_multi
    assign shifted = {data_r[width_p-word_width_p-1:0], data_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
    end else if (clear_i) begin
      data_r <= '0;
    end else if (en_i) begin
      data_r <= shifted;
    end
  end

  assign data_o = data_r;

endmodule

// File: rtl/bsg_aes_input_gather.sv
// Gathers tagged key/plaintext words into a 256-bit key and 128-bit blocks
// and presents {block, key} frames to the AES encrypt core.
//   clk_i       : clock
//   reset_n_i   : synchronous active-low reset
//   data_i      : input word
//   cmd_i       : 1 = key word, 0 = plaintext word
//   v_i         : input word valid
//   ready_o     : word accepted when v_i & ready_o
//   data_o      : frame {block[127:0], key[255:0]}
//   v_o         : frame valid
//   ready_i     : frame consumed when v_o & ready_i
//   key_valid_o : a complete key is held
//   err_o       : sticky protocol error, cleared only by reset
//
// state   | meaning
// S_NOKEY | no key held, waiting for key word 0
// S_KEY   | key partially loaded, kcnt words in
// S_BLK   | key valid, block partially loaded, bcnt words in
// S_FULL  | frame presented, waiting for ready_i
module bsg_aes_input_gather
  import bsg_aes_pkg::*;
#(
  parameter int word_width_p = 32
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [word_width_p-1:0]           data_i,
  input  logic                              cmd_i,
  input  logic                              v_i,
  output logic                              ready_o,
  output logic [bsg_aes_frame_width_gp-1:0] data_o,
  output logic                              v_o,
  input  logic                              ready_i,
  output logic                              key_valid_o,
  output logic                              err_o
);

  localparam int kw_lp      = bsg_aes_key_width_gp / word_width_p;
  localparam int bw_lp      = bsg_aes_block_width_gp / word_width_p;
  localparam int kcnt_w_lp  = (kw_lp > 1) ? $clog2(kw_lp) : 1;
  localparam int bcnt_w_lp  = (bw_lp > 1) ? $clog2(bw_lp) : 1;
  localparam logic [kcnt_w_lp-1:0] kcnt_last_lp = kcnt_w_lp'(kw_lp - 1);
  localparam logic [bcnt_w_lp-1:0] bcnt_last_lp = bcnt_w_lp'(bw_lp - 1);

  bsg_aes_gather_state_e state_r, state_n;
  logic [kcnt_w_lp-1:0]  kcnt_r, kcnt_n;
  logic [bcnt_w_lp-1:0]  bcnt_r, bcnt_n;
  logic                  key_valid_r, key_valid_n;
  logic                  err_r, err_n;
  // Holds ready_o low for the whole reset and rises on the first free cycle.
  logic                  out_of_reset_r;

  logic key_en, key_clr, blk_en, blk_clr;
  logic accept;
  logic [bsg_aes_key_width_gp-1:0]   key_q;
  logic [bsg_aes_block_width_gp-1:0] blk_q;

  assign ready_o = out_of_reset_r & (state_r != S_FULL);
  assign v_o     = (state_r == S_FULL);
  assign accept  = v_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r        <= S_NOKEY;
      kcnt_r         <= '0;
      bcnt_r         <= '0;
      key_valid_r    <= 1'b0;
      err_r          <= 1'b0;
      out_of_reset_r <= 1'b0;
    end else begin
      state_r        <= state_n;
      kcnt_r         <= kcnt_n;
      bcnt_r         <= bcnt_n;
      key_valid_r    <= key_valid_n;
      err_r          <= err_n;
      out_of_reset_r <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state_r;
    kcnt_n      = kcnt_r;
    bcnt_n      = bcnt_r;
    key_valid_n = key_valid_r;
    err_n       = err_r;
    key_en      = 1'b0;
    key_clr     = 1'b0;
    blk_en      = 1'b0;
    blk_clr     = 1'b0;

    unique case (state_r)
      S_NOKEY: begin
        if (accept) begin
          if (cmd_i) begin
            key_en  = 1'b1;
            kcnt_n  = kcnt_w_lp'(1);
            state_n = S_KEY;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_KEY: begin
        if (accept) begin
          if (cmd_i) begin
            key_en = 1'b1;
            if (kcnt_r == kcnt_last_lp) begin
              kcnt_n      = '0;
              key_valid_n = 1'b1;
              state_n     = S_BLK;
            end else begin
              kcnt_n = kcnt_r + kcnt_w_lp'(1);
            end
          end else begin
            // Abort: the partial key is wiped so it can never be presented.
            err_n   = 1'b1;
            kcnt_n  = '0;
            key_clr = 1'b1;
            state_n = S_NOKEY;
          end
        end
      end

      S_BLK: begin
        if (accept) begin
          if (!cmd_i) begin
            blk_en = 1'b1;
            if (bcnt_r == bcnt_last_lp) begin
              bcnt_n  = '0;
              state_n = S_FULL;
            end else begin
              bcnt_n = bcnt_r + bcnt_w_lp'(1);
            end
          end else if (bcnt_r == '0) begin
            key_valid_n = 1'b0;
            key_en      = 1'b1;
            kcnt_n      = kcnt_w_lp'(1);
            state_n     = S_KEY;
          end else begin
            // A key word inside a block is dropped; the partial block survives.
            err_n = 1'b1;
          end
        end
      end

      S_FULL: begin
        if (ready_i) begin
          bcnt_n  = '0;
          blk_clr = 1'b1;
          state_n = S_BLK;
        end
      end

      default: state_n = S_NOKEY;
    endcase
  end

  bsg_aes_shift_in #(
    .width_p     (bsg_aes_key_width_gp),
    .word_width_p(word_width_p)
  ) key_sr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (key_clr),
    .en_i     (key_en),
    .data_i   (data_i),
    .data_o   (key_q)
  );

  bsg_aes_shift_in #(
    .width_p     (bsg_aes_block_width_gp),
    .word_width_p(word_width_p)
  ) blk_sr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (blk_clr),
    .en_i     (blk_en),
    .data_i   (data_i),
    .data_o   (blk_q)
  );

  assign data_o      = {blk_q, key_q};
  assign key_valid_o = key_valid_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_bsg_aes_input_gather.sv
module tb_bsg_aes_input_gather;

  logic         clk = 1'b0;
  logic         reset_n_i;
  logic [31:0]  data_i;
  logic         cmd_i;
  logic         v_i;
  logic         ready_o;
  logic [383:0] data_o;
  logic         v_o;
  logic         ready_i;
  logic         key_valid_o;
  logic         err_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_aes_input_gather #(.word_width_p(32)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n_i),
    .data_i     (data_i),
    .cmd_i      (cmd_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .ready_i    (ready_i),
    .key_valid_o(key_valid_o),
    .err_o      (err_o)
  );

  // Reference model: word-level view of the protocol.
  bit           m_have_key;
  logic [255:0] m_key, m_key_acc;
  int           m_kn;
  logic [127:0] m_blk;
  int           m_bn;
  bit           m_err;
  bit           m_frame;
  logic [383:0] m_frame_data;

  function automatic void model_reset();
    m_have_key = 0; m_key = '0; m_key_acc = '0; m_kn = 0;
    m_blk = '0; m_bn = 0; m_err = 0; m_frame = 0; m_frame_data = '0;
  endfunction

  function automatic void model_word(input bit cmd, input logic [31:0] d);
    m_frame = 0;
    if (cmd) begin
      if (m_bn > 0) m_err = 1;
      else begin
        m_have_key = 0;
        m_key_acc  = (m_key_acc << 32) | {224'd0, d};
        m_kn++;
        if (m_kn == 8) begin
          m_key = m_key_acc; m_have_key = 1; m_kn = 0;
        end
      end
    end else begin
      if (m_kn > 0) begin
        m_err = 1; m_kn = 0;
      end else if (!m_have_key) m_err = 1;
      else begin
        m_blk = (m_blk << 32) | {96'd0, d};
        m_bn++;
        if (m_bn == 4) begin
          m_frame = 1; m_frame_data = {m_blk, m_key}; m_bn = 0;
        end
      end
    end
  endfunction

  // Presents one word, waits (bounded) for acceptance, updates the model.
  task automatic send(input bit cmd, input logic [31:0] d, output bit to);
    int n;
    to = 0; n = 0;
    v_i = 1'b1; cmd_i = cmd; data_i = d;
    while (ready_o !== 1'b1 && n < 40) begin
      if (n == 3) ready_i = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (n >= 40) to = 1;
    else begin
      @(posedge clk); #1;
      model_word(cmd, d);
    end
    v_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; v_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; v_i = 1'b0; cmd_i = 1'b0; data_i = '0; ready_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_o got=%b exp=0", ready_o); end
    checks++; if (key_valid_o !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", key_valid_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", ready_o); end
  endtask

  task automatic test_vector();
    logic [383:0] exp_frame;
    logic [31:0]  pt [4];
    bit to;
    exp_frame = 384'h00112233445566778899aabbccddeeff_000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pt[0] = 32'h00112233; pt[1] = 32'h44556677; pt[2] = 32'h8899aabb; pt[3] = 32'hccddeeff;
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) send(1'b1, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, to);
      else       send(1'b0, pt[i-8], to);
      checks++; if (to) begin failures++; $display("FAIL vec_timeout word=%0d", i); end
      checks++; if (key_valid_o !== (i >= 7)) begin failures++; $display("FAIL vec_key_valid word=%0d got=%b exp=%b", i, key_valid_o, (i >= 7)); end
      checks++; if (v_o !== (i == 11)) begin failures++; $display("FAIL vec_v_o word=%0d got=%b exp=%b", i, v_o, (i == 11)); end
    end
    checks++; if (data_o !== exp_frame) begin failures++; $display("FAIL vec_frame got=%h exp=%h", data_o, exp_frame); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL vec_ready_full got=%b exp=0", ready_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL vec_err got=%b exp=0", err_o); end
    @(posedge clk); #1;
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL vec_handoff v_o=%b ready_o=%b exp v_o=0 ready_o=1", v_o, ready_o); end
  endtask

  task automatic test_stall();
    bit to;
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, $urandom, to);
      checks++; if (to) begin failures++; $display("FAIL stall_timeout word=%0d", i); end
    end
    for (int c = 0; c < 5; c++) begin
      checks++; if (v_o !== 1'b1 || ready_o !== 1'b0) begin failures++; $display("FAIL stall_hold cyc=%0d v_o=%b ready_o=%b exp 1/0", c, v_o, ready_o); end
      checks++; if (data_o !== m_frame_data) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, data_o, m_frame_data); end
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL stall_release v_o=%b ready_o=%b exp 0/1", v_o, ready_o); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int t_first;
    logic [255:0] key_before;
    key_before = m_key;
    ready_i = 1'b1;
    t_first = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, $urandom, to);
      checks++; if (to) begin failures++; $display("FAIL b2b_timeout word=%0d", i); end
      checks++; if (v_o !== m_frame) begin failures++; $display("FAIL b2b_v_o word=%0d got=%b exp=%b", i, v_o, m_frame); end
      if (m_frame) begin
        checks++; if (data_o !== m_frame_data) begin failures++; $display("FAIL b2b_frame word=%0d got=%h exp=%h", i, data_o, m_frame_data); end
        checks++; if (data_o[255:0] !== key_before) begin failures++; $display("FAIL b2b_key word=%0d got=%h exp=%h", i, data_o[255:0], key_before); end
        if (i == 3) t_first = cyc;
        else begin
          checks++; if (cyc - t_first != 5) begin failures++; $display("FAIL b2b_period got=%0d exp=5", cyc - t_first); end
        end
      end
    end
  endtask

  task automatic test_pt_after_reset();
    bit to;
    do_reset();
    ready_i = 1'b1;
    send(1'b0, 32'hdeadbeef, to);
    checks++; if (to) begin failures++; $display("FAIL par_accept timed out"); end
    checks++; if (err_o !== 1'b1 || v_o !== 1'b0) begin failures++; $display("FAIL par_err err=%b v_o=%b exp 1/0", err_o, v_o); end
    for (int i = 0; i < 12; i++) begin
      send(i < 8, $urandom, to);
      checks++; if (to) begin failures++; $display("FAIL par_timeout word=%0d", i); end
      checks++; if (v_o !== m_frame || err_o !== 1'b1) begin failures++; $display("FAIL par_flags word=%0d v_o=%b err=%b exp %b/1", i, v_o, err_o, m_frame); end
    end
    checks++; if (data_o !== m_frame_data) begin failures++; $display("FAIL par_frame got=%h exp=%h", data_o, m_frame_data); end
  endtask

  task automatic test_key_mid_block();
    bit to;
    logic [31:0] pt [4];
    logic [255:0] key_exp;
    do_reset();
    ready_i = 1'b1;
    key_exp = '0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] k;
      k = $urandom;
      key_exp = (key_exp << 32) | {224'd0, k};
      send(1'b1, k, to);
    end
    for (int i = 0; i < 4; i++) pt[i] = $urandom;
    send(1'b0, pt[0], to);
    send(1'b0, pt[1], to);
    send(1'b1, 32'h5a5a5a5a, to);
    checks++; if (err_o !== 1'b1 || key_valid_o !== 1'b1) begin failures++; $display("FAIL kmb_err err=%b kv=%b exp 1/1", err_o, key_valid_o); end
    send(1'b0, pt[2], to);
    checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL kmb_early_v got=%b exp=0", v_o); end
    send(1'b0, pt[3], to);
    checks++; if (to || v_o !== 1'b1) begin failures++; $display("FAIL kmb_v_o got=%b exp=1", v_o); end
    checks++; if (data_o !== {pt[0], pt[1], pt[2], pt[3], key_exp}) begin failures++; $display("FAIL kmb_frame got=%h exp=%h", data_o, {pt[0], pt[1], pt[2], pt[3], key_exp}); end
    checks++; if (data_o !== m_frame_data) begin failures++; $display("FAIL kmb_model got=%h exp=%h", data_o, m_frame_data); end
  endtask

  task automatic test_reset_mid_key();
    bit to;
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, $urandom, to);
    reset_n_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (data_o !== '0 || v_o !== 1'b0 || ready_o !== 1'b0 || key_valid_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL rmk_outputs data=%h v=%b rdy=%b kv=%b err=%b exp all 0", data_o, v_o, ready_o, key_valid_o, err_o);
    end
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      send(1'b0, $urandom, to);
      checks++; if (to || v_o !== 1'b0 || err_o !== 1'b1 || key_valid_o !== 1'b0) begin
        failures++; $display("FAIL rmk_stream word=%0d to=%b v=%b err=%b kv=%b exp 0/0/1/0", i, to, v_o, err_o, key_valid_o);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    bit cmd;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ready_i = ($urandom_range(0, 2) != 0);
      cmd = (i < 8) ? 1'b1 : ($urandom_range(0, 9) == 0);
      send(cmd, $urandom, to);
      checks++; if (to) begin failures++; $display("FAIL rnd_timeout iter=%0d", i); end
      checks++; if (v_o !== m_frame || key_valid_o !== m_have_key || err_o !== m_err) begin
        failures++; $display("FAIL rnd_flags iter=%0d v=%b kv=%b err=%b exp %b/%b/%b", i, v_o, key_valid_o, err_o, m_frame, m_have_key, m_err);
      end
      if (m_frame) begin
        checks++; if (data_o !== m_frame_data) begin failures++; $display("FAIL rnd_frame iter=%0d got=%h exp=%h", i, data_o, m_frame_data); end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; cmd_i = 1'b0; data_i = '0; ready_i = 1'b0;
    model_reset();
    test_reset();
    test_vector();
    test_stall();
    test_back_to_back();
    test_pt_after_reset();
    test_key_mid_block();
    test_reset_mid_key();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
